// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: access sizes, requester ids and byte-lane masks.
package ram_port_arbiter_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ReqIf  = 2'd0,
        ReqLsu = 2'd1,
        ReqDbg = 2'd2
    } req_id_e;

    localparam logic [3:0] BWE_NONE    = 4'b0000;
    localparam logic [3:0] BWE_BYTE0   = 4'b0001;
    localparam logic [3:0] BWE_HALF_LO = 4'b0011;
    localparam logic [3:0] BWE_HALF_HI = 4'b1100;
    localparam logic [3:0] BWE_WORD    = 4'b1111;

endpackage

// File: rtl/ram_req_decode.sv
// Byte address + size -> word address, byte-lane enables and fault flag (range/alignment/size).
module ram_req_decode
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 9
) (
    input  logic [XLEN-1:0] addr_i,
    input  logic [1:0]      size_i,
    output logic [AW-1:0]   waddr_o,
    output logic [3:0]      byte_we_o,
    output logic            fault_o
);

    logic out_of_range;
    logic misaligned;

    assign waddr_o      = addr_i[AW+1:2];
    assign out_of_range = |addr_i[XLEN-1:AW+2];

    always_comb begin
        misaligned = 1'b0;
        byte_we_o  = BWE_NONE;
        unique case (size_i)
            SIZE_BYTE: begin
                byte_we_o = BWE_BYTE0 << addr_i[1:0];
            end
            SIZE_HALF: begin
                misaligned = addr_i[0];
                byte_we_o  = addr_i[1] ? BWE_HALF_HI : BWE_HALF_LO;
            end
            SIZE_WORD: begin
                misaligned = |addr_i[1:0];
                byte_we_o  = BWE_WORD;
            end
            default: begin
                // Illegal size is reported through the same fault path.
                misaligned = 1'b1;
            end
        endcase
    end

    assign fault_o = out_of_range | misaligned;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates IF, LSU and DBG onto a 1W/2R synchronous RAM, stalling reads that hit a same-cycle write.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_err_o,

    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_size_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_err_o,

    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    output logic            dbg_gnt_o,

    output logic            ram_cs_o,
    output logic            ram_we_o,
    output logic [3:0]      ram_byte_we_o,
    output logic [AW-1:0]   ram_waddr_o,
    output logic [XLEN-1:0] ram_wdata_o,
    output logic            ram_re1_o,
    output logic [AW-1:0]   ram_raddr1_o,
    input  logic [XLEN-1:0] ram_rdata1_i,
    output logic            ram_re2_o,
    output logic [AW-1:0]   ram_raddr2_o,
    input  logic [XLEN-1:0] ram_rdata2_i
);

    logic [AW-1:0] if_waddr, lsu_waddr, dbg_waddr;
    logic [3:0]    lsu_bwe, unused_if_bwe, unused_dbg_bwe;
    logic          if_fault, lsu_fault, dbg_fault;

    ram_req_decode #(.XLEN(XLEN), .AW(AW)) u_dec_if (
        .addr_i    (if_addr_i),
        .size_i    (SIZE_WORD),
        .waddr_o   (if_waddr),
        .byte_we_o (unused_if_bwe),
        .fault_o   (if_fault)
    );

    ram_req_decode #(.XLEN(XLEN), .AW(AW)) u_dec_lsu (
        .addr_i    (lsu_addr_i),
        .size_i    (lsu_size_i),
        .waddr_o   (lsu_waddr),
        .byte_we_o (lsu_bwe),
        .fault_o   (lsu_fault)
    );

    ram_req_decode #(.XLEN(XLEN), .AW(AW)) u_dec_dbg (
        .addr_i    (dbg_addr_i),
        .size_i    (SIZE_WORD),
        .waddr_o   (dbg_waddr),
        .byte_we_o (unused_dbg_bwe),
        .fault_o   (dbg_fault)
    );

    req_id_e last_wr_grant_q, last_wr_grant_d;
    logic    if_rvalid_q, if_err_q;
    logic    lsu_rvalid_q, lsu_err_q, lsu_load_q;

    logic if_rd_want, lsu_rd_want, lsu_wr_want, dbg_wr_want;
    logic if_rd_gnt, lsu_rd_gnt, lsu_wr_gnt, dbg_wr_gnt;

    always_comb begin
        if_rd_want  = if_req_i & ~if_fault;
        lsu_rd_want = lsu_req_i & ~lsu_we_i & ~lsu_fault;
        lsu_wr_want = lsu_req_i & lsu_we_i & ~lsu_fault;
        dbg_wr_want = dbg_req_i & ~dbg_fault;

        dbg_wr_gnt = 1'b0;
        lsu_wr_gnt = 1'b0;
        if (!rst) begin
            if (dbg_wr_want && lsu_wr_want) begin
                // Round-robin: whoever did not win the last write goes first.
                if (last_wr_grant_q == ReqLsu) begin
                    dbg_wr_gnt = 1'b1;
                end else begin
                    lsu_wr_gnt = 1'b1;
                end
            end else begin
                dbg_wr_gnt = dbg_wr_want;
                lsu_wr_gnt = lsu_wr_want;
            end
        end

        ram_we_o      = dbg_wr_gnt | lsu_wr_gnt;
        ram_waddr_o   = dbg_wr_gnt ? dbg_waddr : lsu_waddr;
        ram_wdata_o   = dbg_wr_gnt ? dbg_wdata_i : lsu_wdata_i;
        ram_byte_we_o = dbg_wr_gnt ? BWE_WORD : (lsu_wr_gnt ? lsu_bwe : BWE_NONE);

        // A read to the word being written this cycle waits one cycle to see the new data.
        if_rd_gnt  = ~rst & if_rd_want & ~(ram_we_o && (if_waddr == ram_waddr_o));
        lsu_rd_gnt = ~rst & lsu_rd_want & ~(ram_we_o && (lsu_waddr == ram_waddr_o));

        if_gnt_o  = if_rd_gnt | (~rst & if_req_i & if_fault);
        lsu_gnt_o = lsu_rd_gnt | lsu_wr_gnt | (~rst & lsu_req_i & lsu_fault);
        dbg_gnt_o = dbg_wr_gnt | (~rst & dbg_req_i & dbg_fault);

        ram_re1_o    = if_rd_gnt;
        ram_raddr1_o = if_waddr;
        ram_re2_o    = lsu_rd_gnt;
        ram_raddr2_o = lsu_waddr;
        ram_cs_o     = ram_we_o | ram_re1_o | ram_re2_o;

        last_wr_grant_d = last_wr_grant_q;
        if (dbg_wr_gnt) begin
            last_wr_grant_d = ReqDbg;
        end else if (lsu_wr_gnt) begin
            last_wr_grant_d = ReqLsu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr_grant_q <= ReqLsu;
            if_rvalid_q     <= 1'b0;
            if_err_q        <= 1'b0;
            lsu_rvalid_q    <= 1'b0;
            lsu_err_q       <= 1'b0;
            lsu_load_q      <= 1'b0;
        end else begin
            last_wr_grant_q <= last_wr_grant_d;
            if_rvalid_q     <= if_gnt_o;
            if_err_q        <= if_gnt_o & if_fault;
            lsu_rvalid_q    <= lsu_gnt_o;
            lsu_err_q       <= lsu_gnt_o & lsu_fault;
            lsu_load_q      <= lsu_rd_gnt;
        end
    end

    // Responses in flight are suppressed while reset is held.
    always_comb begin
        if_rvalid_o  = if_rvalid_q & ~rst;
        if_err_o     = if_err_q & ~rst;
        if_rdata_o   = (if_rvalid_o && !if_err_q) ? ram_rdata1_i : '0;
        lsu_rvalid_o = lsu_rvalid_q & ~rst;
        lsu_err_o    = lsu_err_q & ~rst;
        lsu_rdata_o  = (lsu_rvalid_o && lsu_load_q) ? ram_rdata2_i : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1W/2R RAM behind it.
module tb_ram_port_arbiter;

    localparam int unsigned AW = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        dbg_req, dbg_gnt;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        ram_cs, ram_we, ram_re1, ram_re2;
    logic [3:0]  ram_byte_we;
    logic [AW-1:0] ram_waddr, ram_raddr1, ram_raddr2;
    logic [31:0] ram_wdata, ram_rdata1, ram_rdata2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.DEPTH(512), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_gnt_o      (if_gnt),
        .if_rvalid_o   (if_rvalid),
        .if_rdata_o    (if_rdata),
        .if_err_o      (if_err),
        .lsu_req_i     (lsu_req),
        .lsu_we_i      (lsu_we),
        .lsu_size_i    (lsu_size),
        .lsu_addr_i    (lsu_addr),
        .lsu_wdata_i   (lsu_wdata),
        .lsu_gnt_o     (lsu_gnt),
        .lsu_rvalid_o  (lsu_rvalid),
        .lsu_rdata_o   (lsu_rdata),
        .lsu_err_o     (lsu_err),
        .dbg_req_i     (dbg_req),
        .dbg_addr_i    (dbg_addr),
        .dbg_wdata_i   (dbg_wdata),
        .dbg_gnt_o     (dbg_gnt),
        .ram_cs_o      (ram_cs),
        .ram_we_o      (ram_we),
        .ram_byte_we_o (ram_byte_we),
        .ram_waddr_o   (ram_waddr),
        .ram_wdata_o   (ram_wdata),
        .ram_re1_o     (ram_re1),
        .ram_raddr1_o  (ram_raddr1),
        .ram_rdata1_i  (ram_rdata1),
        .ram_re2_o     (ram_re2),
        .ram_raddr2_o  (ram_raddr2),
        .ram_rdata2_i  (ram_rdata2)
    );

    logic [31:0] mem [512];

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byte_we[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_re1) ram_rdata1 <= mem[ram_raddr1];
        if (ram_re2) ram_rdata2 <= mem[ram_raddr2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0;
        lsu_req = 0; lsu_we = 0; lsu_size = 0; lsu_addr = 0; lsu_wdata = 0;
        dbg_req = 0; dbg_addr = 0; dbg_wdata = 0;
        tick(); tick();

        // Reset: requests are ignored, nothing enabled
        if_req = 1; if_addr = 32'h10;
        #1;
        check("rst_if_gnt", 32'(if_gnt), 0);
        check("rst_ram_cs", 32'(ram_cs), 0);
        check("rst_if_rvalid", 32'(if_rvalid), 0);
        check("rst_lsu_rvalid", 32'(lsu_rvalid), 0);
        check("rst_errs", 32'({if_err, lsu_err}), 0);
        if_req = 0;
        rst = 0;
        tick();

        // DBG preloads word 4 and word 9
        dbg_req = 1; dbg_addr = 32'h10; dbg_wdata = 32'h1111_1111;
        #1;
        check("dbg_gnt", 32'(dbg_gnt), 1);
        check("dbg_we", 32'(ram_we), 1);
        check("dbg_waddr", 32'(ram_waddr), 4);
        check("dbg_bwe", 32'(ram_byte_we), 32'hF);
        tick();
        dbg_addr = 32'h24; dbg_wdata = 32'h2222_2222;
        #1;
        check("dbg_gnt2", 32'(dbg_gnt), 1);
        tick();
        dbg_req = 0;

        // Concurrent IF and LSU reads
        if_req = 1; if_addr = 32'h10;
        lsu_req = 1; lsu_we = 0; lsu_size = 2; lsu_addr = 32'h24;
        #1;
        check("cr_if_gnt", 32'(if_gnt), 1);
        check("cr_lsu_gnt", 32'(lsu_gnt), 1);
        check("cr_raddr1", 32'(ram_raddr1), 4);
        check("cr_raddr2", 32'(ram_raddr2), 9);
        tick();
        if_req = 0; lsu_req = 0;
        #1;
        check("cr_if_rvalid", 32'(if_rvalid), 1);
        check("cr_if_rdata", if_rdata, 32'h1111_1111);
        check("cr_lsu_rvalid", 32'(lsu_rvalid), 1);
        check("cr_lsu_rdata", lsu_rdata, 32'h2222_2222);
        check("cr_lsu_err", 32'(lsu_err), 0);

        // Byte store to 0x5
        lsu_req = 1; lsu_we = 1; lsu_size = 0; lsu_addr = 32'h5; lsu_wdata = 32'hAB;
        #1;
        check("bs_gnt", 32'(lsu_gnt), 1);
        check("bs_we", 32'(ram_we), 1);
        check("bs_waddr", 32'(ram_waddr), 1);
        check("bs_bwe", 32'(ram_byte_we), 32'b0010);
        check("bs_wdata", 32'(ram_wdata[7:0]), 32'hAB);
        tick();
        lsu_req = 0;
        #1;
        check("bs_rvalid", 32'(lsu_rvalid), 1);
        check("bs_rdata", lsu_rdata, 0);

        // Collision: LSU store and IF fetch on word 0x40
        lsu_req = 1; lsu_we = 1; lsu_size = 2; lsu_addr = 32'h40; lsu_wdata = 32'hDEAD_BEEF;
        if_req = 1; if_addr = 32'h40;
        #1;
        check("col_lsu_gnt", 32'(lsu_gnt), 1);
        check("col_if_gnt0", 32'(if_gnt), 0);
        check("col_re1_0", 32'(ram_re1), 0);
        tick();
        lsu_req = 0;
        #1;
        check("col_if_gnt1", 32'(if_gnt), 1);
        check("col_st_rvalid", 32'(lsu_rvalid), 1);
        tick();
        if_req = 0;
        #1;
        check("col_if_rvalid", 32'(if_rvalid), 1);
        check("col_if_rdata", if_rdata, 32'hDEAD_BEEF);

        // Collision: DBG write vs LSU load on the same word
        dbg_req = 1; dbg_addr = 32'h40; dbg_wdata = 32'h1234_5678;
        lsu_req = 1; lsu_we = 0; lsu_size = 2; lsu_addr = 32'h40;
        #1;
        check("col2_dbg_gnt", 32'(dbg_gnt), 1);
        check("col2_lsu_gnt0", 32'(lsu_gnt), 0);
        tick();
        dbg_req = 0;
        #1;
        check("col2_lsu_gnt1", 32'(lsu_gnt), 1);
        tick();
        lsu_req = 0;
        #1;
        check("col2_lsu_rdata", lsu_rdata, 32'h1234_5678);

        // Write contention after reset: DBG, LSU, DBG, LSU
        rst = 1;
        tick();
        rst = 0;
        dbg_req = 1; dbg_addr = 32'h100; dbg_wdata = 32'hA;
        lsu_req = 1; lsu_we = 1; lsu_size = 2; lsu_addr = 32'h104; lsu_wdata = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wc%0d_dbg_gnt", i), 32'(dbg_gnt), 32'((i % 2) == 0));
            check($sformatf("wc%0d_lsu_gnt", i), 32'(lsu_gnt), 32'((i % 2) == 1));
            tick();
        end
        dbg_req = 0; lsu_req = 0;

        // Faults: misaligned half, out-of-range word, illegal size
        lsu_req = 1; lsu_we = 0; lsu_size = 1; lsu_addr = 32'h3;
        #1;
        check("f1_gnt", 32'(lsu_gnt), 1);
        check("f1_en", 32'({ram_we, ram_re2}), 0);
        tick();
        lsu_size = 2; lsu_addr = 32'h800;
        #1;
        check("f1_rvalid", 32'(lsu_rvalid), 1);
        check("f1_err", 32'(lsu_err), 1);
        check("f1_rdata", lsu_rdata, 0);
        check("f2_gnt", 32'(lsu_gnt), 1);
        check("f2_en", 32'({ram_we, ram_re2}), 0);
        tick();
        lsu_we = 1; lsu_size = 3; lsu_addr = 32'h0;
        #1;
        check("f2_err", 32'({lsu_rvalid, lsu_err}), 32'b11);
        check("f3_gnt", 32'(lsu_gnt), 1);
        check("f3_we", 32'(ram_we), 0);
        tick();
        lsu_req = 0;
        dbg_req = 1; dbg_addr = 32'h802; dbg_wdata = 32'h5;
        #1;
        check("f3_err", 32'({lsu_rvalid, lsu_err}), 32'b11);
        check("fd_gnt", 32'(dbg_gnt), 1);
        check("fd_we", 32'(ram_we), 0);
        tick();
        dbg_req = 0;
        #1;
        check("f_idle_rvalid", 32'(lsu_rvalid), 0);

        // Reset in the cycle after an IF grant
        if_req = 1; if_addr = 32'h10;
        #1;
        check("rm_gnt", 32'(if_gnt), 1);
        tick();
        rst = 1;
        #1;
        check("rm_rvalid", 32'(if_rvalid), 0);
        check("rm_cs", 32'(ram_cs), 0);
        check("rm_gnt_rst", 32'(if_gnt), 0);
        tick();
        rst = 0;
        #1;
        check("rm_gnt_after", 32'(if_gnt), 1);
        tick();
        if_req = 0;
        #1;
        check("rm_rvalid_after", 32'(if_rvalid), 1);
        check("rm_rdata_after", if_rdata, 32'h1111_1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
